// File: rtl/div_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and helpers for the shared-divider arbiter and its divider.
//   arb_state_t : arbiter sequencing states
//   div_state_t : divider internal states
//   calc_iter() : number of quotient bits the divider iterates over
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic [2:0] {
    D_IDLE,
    D_ABS,
    D_CALC,
    D_SGN,
    D_FIN
  } div_state_t;

  // One quotient bit per integer magnitude bit plus one per fractional bit.
  function automatic int calc_iter(input int width, input int fbits);
    return width - 1 + fbits;
  endfunction

endpackage

// File: rtl/div_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// div_share_arbiter_if
// Requester-side bundle of the shared divider arbiter.
//   req/a_in/b_in        : per-port request level and signed operands
//   gnt                  : one-hot pulse, operands captured
//   resp_valid           : one-hot pulse, response bus belongs to that port
//   resp_val/ok/dbz/ovf  : shared response bus
//   busy                 : an operation is in flight
// master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface div_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);

  logic [NREQ-1:0]             req;
  logic [NREQ-1:0][WIDTH-1:0]  a_in;
  logic [NREQ-1:0][WIDTH-1:0]  b_in;
  logic [NREQ-1:0]             gnt;
  logic [NREQ-1:0]             resp_valid;
  logic [WIDTH-1:0]            resp_val;
  logic                        resp_ok;
  logic                        resp_dbz;
  logic                        resp_ovf;
  logic                        busy;

  modport master (
    output req, a_in, b_in,
    input  gnt, resp_valid, resp_val, resp_ok, resp_dbz, resp_ovf, busy
  );

  modport slave (
    input  req, a_in, b_in,
    output gnt, resp_valid, resp_val, resp_ok, resp_dbz, resp_ovf, busy
  );

endinterface

// File: rtl/div_share_arbiter_divider.sv
// -----------------------------------------------------------------------------
// divider
// Signed fixed-point divider (WIDTH bits, FBITS fractional), restoring
// long division on magnitudes, one quotient bit per cycle.
//   clk, rst          : clock, synchronous active-high reset
//   start_i           : begin a division with a_i / b_i
//   a_i, b_i          : signed dividend / divisor
//   done_o            : one-cycle pulse, result fields updated
//   val_o             : signed quotient (truncated toward zero)
//   valid_o           : quotient is usable
//   dbz_o, ovf_o      : divide by zero / overflow
// Divide by zero and most-negative operands are rejected immediately (done
// the cycle after start). A quotient that cannot fit is caught as soon as
// its first out-of-range bit appears and ends the division early.
// -----------------------------------------------------------------------------
module divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] val_o,
  output logic             valid_o,
  output logic             dbz_o,
  output logic             ovf_o
);

  localparam int ITER = calc_iter(WIDTH, FBITS);
  localparam int CW   = $clog2(ITER);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             neg_q, neg_d;
  logic [WIDTH-2:0] bm_q, bm_d;
  logic [WIDTH-2:0] rem_q, rem_d;
  logic [ITER-1:0]  dq_q, dq_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             of_q, of_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             valid_q, valid_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-2:0] amag, bmag;
  logic [WIDTH-1:0] rem_shift;
  logic             qbit;

  // Magnitudes fit in WIDTH-1 bits because the most-negative value is
  // rejected before we ever get here.
  assign amag = a_q[WIDTH-1] ? ('0 - a_q[WIDTH-2:0]) : a_q[WIDTH-2:0];
  assign bmag = b_q[WIDTH-1] ? ('0 - b_q[WIDTH-2:0]) : b_q[WIDTH-2:0];

  // dq holds the dividend shifting out the top while quotient bits shift
  // in at the bottom; after ITER steps it holds the quotient magnitude.
  assign rem_shift = {rem_q, dq_q[ITER-1]};
  assign qbit      = (rem_shift >= {1'b0, bm_q});

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= D_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      bm_q    <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      cnt_q   <= '0;
      of_q    <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
      val_q   <= '0;
      valid_q <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      bm_q    <= bm_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      cnt_q   <= cnt_d;
      of_q    <= of_d;
      res_q   <= res_d;
      done_q  <= done_d;
      val_q   <= val_d;
      valid_q <= valid_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: reject check, magnitude prep, bit-serial division, sign
  // restore, then publish the result with a done pulse.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    bm_d    = bm_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    cnt_d   = cnt_q;
    of_d    = of_q;
    res_d   = res_q;
    done_d  = 1'b0;
    val_d   = val_q;
    valid_d = valid_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    case (state_q)
      D_IDLE: begin
        if (start_i) begin
          a_d = a_i;
          b_d = b_i;
          if ((b_i == '0) || (a_i == MINV) || (b_i == MINV)) begin
            done_d  = 1'b1;
            val_d   = '0;
            valid_d = 1'b0;
            dbz_d   = (b_i == '0);
            ovf_d   = (a_i == MINV) || (b_i == MINV);
          end else begin
            state_d = D_ABS;
          end
        end
      end
      D_ABS: begin
        neg_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        bm_d    = bmag;
        dq_d    = {amag, {FBITS{1'b0}}};
        rem_d   = '0;
        cnt_d   = CW'(ITER - 1);
        of_d    = 1'b0;
        state_d = D_CALC;
      end
      D_CALC: begin
        dq_d  = {dq_q[ITER-2:0], qbit};
        rem_d = qbit ? (WIDTH-1)'(rem_shift - {1'b0, bm_q}) : (WIDTH-1)'(rem_shift);
        // A set bit at or above the sign position cannot be represented.
        if (qbit && (cnt_q >= CW'(WIDTH - 1))) begin
          of_d    = 1'b1;
          state_d = D_FIN;
        end else if (cnt_q == '0) begin
          state_d = D_SGN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      D_SGN: begin
        res_d   = neg_q ? ('0 - dq_q[WIDTH-1:0]) : dq_q[WIDTH-1:0];
        state_d = D_FIN;
      end
      D_FIN: begin
        done_d  = 1'b1;
        dbz_d   = 1'b0;
        ovf_d   = of_q;
        valid_d = !of_q;
        val_d   = of_q ? '0 : res_q;
        state_d = D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
  end

  assign done_o  = done_q;
  assign val_o   = val_q;
  assign valid_o = valid_q;
  assign dbz_o   = dbz_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/div_share_arbiter.sv
// -----------------------------------------------------------------------------
// div_share_arbiter
// Shares one divider among NREQ requesters with round-robin arbitration.
//   clk, rst : clock, synchronous active-high reset (also resets divider)
//   bus      : div_share_arbiter_if.slave -- per-port req/operands in,
//              gnt/resp_valid pulses and shared response bus out
// Sequence: IDLE (arbitrate, capture) -> LAUNCH (gnt + start) -> WAIT
// (divider running) -> RESP (resp_valid to owner) -> IDLE.
// -----------------------------------------------------------------------------
module div_share_arbiter
  import div_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FBITS = 4,
  parameter int NREQ  = 4
) (
  input  logic                clk,
  input  logic                rst,
  div_share_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NREQ);

  arb_state_t       state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    pick;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  rv_q, rv_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             ok_q, ok_d, dbz_q, dbz_d, ovf_q, ovf_d;

  logic             div_done, div_valid, div_dbz, div_ovf;
  logic [WIDTH-1:0] div_val;

  // Round-robin: rotate so the port after 'last' sits at bit 0, take the
  // lowest set bit, then rotate the index back.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   last);
    logic [NREQ-1:0] rot;
    int base;
    int hit;
    base = (int'(last) + 1) % NREQ;
    for (int i = 0; i < NREQ; i++) begin
      rot[IW'(i)] = r[IW'((base + i) % NREQ)];
    end
    hit = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[IW'(i)]) hit = i;
    end
    return IW'((base + hit) % NREQ);
  endfunction

  assign pick = rr_pick(bus.req, last_q);

  divider #(
    .WIDTH (WIDTH),
    .FBITS (FBITS)
  ) u_divider (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_q),
    .a_i     (a_q),
    .b_i     (b_q),
    .done_o  (div_done),
    .val_o   (div_val),
    .valid_o (div_valid),
    .dbz_o   (div_dbz),
    .ovf_o   (div_ovf)
  );

  // State register; last starts at NREQ-1 so port 0 wins the first search.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IW'(NREQ - 1);
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gnt_q   <= '0;
      rv_q    <= '0;
      start_q <= 1'b0;
      val_q   <= '0;
      ok_q    <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gnt_q   <= gnt_d;
      rv_q    <= rv_d;
      start_q <= start_d;
      val_q   <= val_d;
      ok_q    <= ok_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and registered-output intent. gnt/start/resp_valid are set
  // one state early so they appear as registered pulses in LAUNCH / RESP.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    gnt_d   = '0;
    rv_d    = '0;
    start_d = 1'b0;
    val_d   = val_q;
    ok_d    = ok_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          owner_d     = pick;
          a_d         = bus.a_in[pick];
          b_d         = bus.b_in[pick];
          gnt_d[pick] = 1'b1;
          start_d     = 1'b1;
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (div_done) begin
          val_d         = div_val;
          ok_d          = div_valid;
          dbz_d         = div_dbz;
          ovf_d         = div_ovf;
          rv_d[owner_q] = 1'b1;
          state_d       = RESP;
        end
      end
      RESP: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt        = gnt_q;
  assign bus.resp_valid = rv_q;
  assign bus.resp_val   = val_q;
  assign bus.resp_ok    = ok_q;
  assign bus.resp_dbz   = dbz_q;
  assign bus.resp_ovf   = ovf_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
